// File: rtl/cmd_timing_gate_if.sv
// Request/issue handshake plus live per-bank timing status for cmd_timing_gate.
// master: command source / timing tracker side; slave: the gate itself.
interface cmd_timing_gate_if #(
  parameter int NUM_BANK = 8,
  parameter int CNT_W    = 5
);
  logic                      req_valid;
  logic                      req_ready;
  logic [2:0]                req_cmd;
  logic [2:0]                req_bank;
  logic [NUM_BANK*CNT_W-1:0] bank_tp_cnt;
  logic [NUM_BANK*3-1:0]     bank_recode;
  logic                      issue_valid;
  logic [2:0]                issue_cmd;
  logic [2:0]                issue_bank;
  logic                      illegal_err;
  logic                      timeout_err;

  modport master (
    output req_valid, req_cmd, req_bank, bank_tp_cnt, bank_recode,
    input  req_ready, issue_valid, issue_cmd, issue_bank, illegal_err, timeout_err
  );

  modport slave (
    input  req_valid, req_cmd, req_bank, bank_tp_cnt, bank_recode,
    output req_ready, issue_valid, issue_cmd, issue_bank, illegal_err, timeout_err
  );
endinterface

// File: rtl/cmd_timing_gate.sv
// Holds one DRAM command until its bank timing, tRRD and tFAW allow it, then
// releases it as a one-cycle issue pulse; drops illegal or starved requests.
module cmd_timing_gate #(
  parameter int NUM_BANK = 8,
  parameter int CNT_W    = 5,
  parameter int TRRD     = 4,
  parameter int TFAW     = 20,
  parameter int TMO      = 255
) (
  input logic clk,
  input logic rst_n,
  cmd_timing_gate_if.slave bus
);
  localparam int RRD_W = $clog2(TRRD) + 1;
  localparam int FAW_W = $clog2(TFAW) + 1;
  localparam logic [2:0] CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4, CMD_REF = 3'd5;
  localparam logic [2:0] RC_WR2PRE = 3'd1, RC_PRE2ACT = 3'd2;
  localparam logic [2:0] RC_ACT2RW = 3'd3, RC_RD2PRE = 3'd4;
  localparam logic [7:0] TMO_L = 8'(TMO);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d, bank_q, bank_d;
  logic [7:0]       wait_q, wait_d;
  logic [RRD_W-1:0] rrd_q, rrd_d;
  logic [FAW_W-1:0] faw_q [4];
  logic [FAW_W-1:0] faw_d [4];
  logic             issue_valid_q, issue_valid_d;
  logic [2:0]       issue_cmd_q, issue_cmd_d, issue_bank_q, issue_bank_d;
  logic             illegal_q, illegal_d, timeout_q, timeout_d;
  logic             req_ready, ok, act_issue, slot_found;
  logic             sel_zero;
  logic [2:0]       sel_rc;

  logic [NUM_BANK-1:0] cnt_zero;
  logic [2:0]          rc_arr [NUM_BANK];
  logic [3:0]          faw_zero;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
      assign cnt_zero[gi] = (bus.bank_tp_cnt[gi*CNT_W +: CNT_W] == '0);
      assign rc_arr[gi]   = bus.bank_recode[gi*3 +: 3];
    end
    for (gi = 0; gi < 4; gi++) begin : g_faw
      assign faw_zero[gi] = (faw_q[gi] == '0);
    end
  endgenerate

  // Bank status is sampled live every WAIT cycle, never latched.
  always_comb begin
    sel_zero = cnt_zero[bank_q];
    sel_rc   = rc_arr[bank_q];
    ok       = 1'b0;
    case (cmd_q)
      CMD_ACT:        ok = ((sel_rc != RC_PRE2ACT) || sel_zero) && (rrd_q == '0) && (|faw_zero);
      CMD_RD, CMD_WR: ok = (sel_rc != RC_ACT2RW) || sel_zero;
      CMD_PRE:        ok = !((sel_rc == RC_WR2PRE) || (sel_rc == RC_RD2PRE)) || sel_zero;
      CMD_REF:        ok = &cnt_zero;
      default:        ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    bank_d        = bank_q;
    wait_d        = wait_q;
    issue_valid_d = 1'b0;
    issue_cmd_d   = 3'd0;
    issue_bank_d  = 3'd0;
    illegal_d     = 1'b0;
    timeout_d     = 1'b0;
    req_ready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        wait_d    = 8'd0;
        if (bus.req_valid) begin
          if (bus.req_cmd >= CMD_ACT && bus.req_cmd <= CMD_REF) begin
            cmd_d   = bus.req_cmd;
            bank_d  = bus.req_bank;
            state_d = S_WAIT;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ok) begin
          state_d       = S_ISSUE;
          issue_valid_d = 1'b1;
          issue_cmd_d   = cmd_q;
          issue_bank_d  = bank_q;
          wait_d        = 8'd0;
        end else if (wait_q == TMO_L) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          wait_d    = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        wait_d  = 8'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tRRD / tFAW tracking; a new ACT claims the lowest free window slot.
  always_comb begin
    act_issue  = (state_q == S_ISSUE) && (cmd_q == CMD_ACT);
    rrd_d      = act_issue ? RRD_W'(TRRD - 1) : ((rrd_q == '0) ? '0 : rrd_q - 1'b1);
    slot_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      faw_d[i] = (faw_q[i] == '0) ? '0 : faw_q[i] - 1'b1;
      if (act_issue && !slot_found && faw_zero[i]) begin
        faw_d[i]   = FAW_W'(TFAW - 1);
        slot_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmd_q         <= 3'd0;
      bank_q        <= 3'd0;
      wait_q        <= 8'd0;
      rrd_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_cmd_q   <= 3'd0;
      issue_bank_q  <= 3'd0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      for (int i = 0; i < 4; i++) faw_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      bank_q        <= bank_d;
      wait_q        <= wait_d;
      rrd_q         <= rrd_d;
      issue_valid_q <= issue_valid_d;
      issue_cmd_q   <= issue_cmd_d;
      issue_bank_q  <= issue_bank_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      for (int i = 0; i < 4; i++) faw_q[i] <= faw_d[i];
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_cmd   = issue_cmd_q;
  assign bus.issue_bank  = issue_bank_q;
  assign bus.illegal_err = illegal_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_cmd_timing_gate.sv
// Directed + random bench for cmd_timing_gate against a rule-level model that
// tracks the pending request, its wait count and the history of ACT issue times.
module tb_cmd_timing_gate;
  localparam int NB = 8, CW = 5, TRRD = 4, TFAW = 20, TMO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  cmd_timing_gate_if #(.NUM_BANK(NB), .CNT_W(CW)) bus ();
  cmd_timing_gate #(.NUM_BANK(NB), .CNT_W(CW), .TRRD(TRRD), .TFAW(TFAW), .TMO(TMO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt_a [NB];
  logic [2:0] rc_a [NB];
  bit dec_en;

  // Model state
  bit m_pend;
  logic [2:0] m_cmd, m_bank;
  int m_waited;
  bit e_issue, e_ill, e_tmo;
  logic [2:0] e_cmd, e_bank;
  int act_times[$];
  int now;
  // Observations
  int issue_times[$];
  int tmo_seen, ill_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rule_ok();
    int c = cnt_a[m_bank];
    logic [2:0] rc = rc_a[m_bank];
    int n_rrd = 0, n_faw = 0;
    bit all0 = 1'b1;
    foreach (act_times[i]) begin
      if (now - act_times[i] < TRRD) n_rrd++;
      if (now - act_times[i] < TFAW) n_faw++;
    end
    foreach (cnt_a[i]) if (cnt_a[i] != 0) all0 = 1'b0;
    case (m_cmd)
      3'd1:       return (rc != 3'd2 || c == 0) && n_rrd == 0 && n_faw < 4;
      3'd2, 3'd3: return rc != 3'd3 || c == 0;
      3'd4:       return !(rc == 3'd1 || rc == 3'd4) || c == 0;
      3'd5:       return all0;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_pend = 0; m_waited = 0; m_cmd = 0; m_bank = 0;
    e_issue = 0; e_ill = 0; e_tmo = 0; e_cmd = 0; e_bank = 0;
    act_times.delete();
  endtask

  task automatic model_step();
    bit n_issue = 0, n_ill = 0, n_tmo = 0;
    logic [2:0] n_cmd = 0, n_bank = 0;
    if (e_issue) begin
      if (e_cmd == 3'd1) act_times.push_back(now);
    end else if (!m_pend) begin
      if (bus.req_valid) begin
        if (bus.req_cmd >= 3'd1 && bus.req_cmd <= 3'd5) begin
          m_pend = 1; m_cmd = bus.req_cmd; m_bank = bus.req_bank; m_waited = 0;
        end else begin
          n_ill = 1;
        end
      end
    end else if (rule_ok()) begin
      n_issue = 1; n_cmd = m_cmd; n_bank = m_bank; m_pend = 0;
    end else if (m_waited == TMO) begin
      n_tmo = 1; m_pend = 0;
    end else begin
      m_waited++;
    end
    e_issue = n_issue; e_ill = n_ill; e_tmo = n_tmo; e_cmd = n_cmd; e_bank = n_bank;
    now++;
    while (act_times.size() > 0 && now - act_times[0] >= TFAW) void'(act_times.pop_front());
  endtask

  task automatic cycle();
    for (int b = 0; b < NB; b++) begin
      bus.bank_tp_cnt[b*CW +: CW] = CW'(cnt_a[b]);
      bus.bank_recode[b*3 +: 3]   = rc_a[b];
    end
    chk("req_ready",   32'(bus.req_ready),   32'(!m_pend && !e_issue));
    chk("issue_valid", 32'(bus.issue_valid), 32'(e_issue));
    chk("issue_cmd",   32'(bus.issue_cmd),   32'(e_cmd));
    chk("issue_bank",  32'(bus.issue_bank),  32'(e_bank));
    chk("illegal_err", 32'(bus.illegal_err), 32'(e_ill));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
    if (bus.issue_valid) issue_times.push_back(now);
    if (bus.timeout_err) tmo_seen++;
    if (bus.illegal_err) ill_seen++;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (dec_en) foreach (cnt_a[i]) if (cnt_a[i] > 0) cnt_a[i]--;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] b, output int t_acc);
    t_acc = -1;
    bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_bank = b;
    for (int k = 0; k < 600; k++) begin
      if (bus.req_ready) begin
        t_acc = now;
        cycle();
        break;
      end
      cycle();
    end
    bus.req_valid = 1'b0;
    chk("accept_bound", 32'(t_acc >= 0), 32'd1);
  endtask

  task automatic wait_issues(input int want, input int bound);
    for (int k = 0; k < bound && issue_times.size() < want; k++) cycle();
    chk("issue_bound", 32'(issue_times.size() >= want), 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready",   32'(bus.req_ready),   32'd1);
    chk("rst_issue_v", 32'(bus.issue_valid), 32'd0);
    chk("rst_issue_c", 32'(bus.issue_cmd),   32'd0);
    chk("rst_issue_b", 32'(bus.issue_bank),  32'd0);
    chk("rst_ill",     32'(bus.illegal_err), 32'd0);
    chk("rst_tmo",     32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, n0, base, t1;
    logic [2:0] rct [6];
    rct = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    bus.req_valid = 0; bus.req_cmd = 0; bus.req_bank = 0;
    bus.bank_tp_cnt = '0; bus.bank_recode = '0;
    foreach (cnt_a[i]) begin cnt_a[i] = 0; rc_a[i] = 3'd0; end
    dec_en = 0; now = 0; tmo_seen = 0; ill_seen = 0;
    model_clear();
    @(negedge clk);
    do_reset();
    run(3);

    // RD bank 2, ACTIVE_TO_READ_WRITE with cnt 0: issue two cycles after accept
    rc_a[2] = 3'd3;
    n0 = issue_times.size();
    send(3'd2, 3'd2, ta);
    wait_issues(n0 + 1, 20);
    if (issue_times.size() > n0) chk("r019_latency", 32'(issue_times[n0] - ta), 32'd2);
    run(3);

    // ACT bank 1 waiting on PRECHARGE_TO_ACTIVE counter 5 -> 0
    dec_en = 1; rc_a[1] = 3'd2; cnt_a[1] = 5;
    n0 = issue_times.size();
    send(3'd1, 3'd1, ta);
    wait_issues(n0 + 1, 30);
    if (issue_times.size() > n0) chk("r020_latency", 32'(issue_times[n0] - ta), 32'd6);
    run(TFAW + 5);

    // Five back-to-back ACTs: tRRD spacing and tFAW window
    foreach (rc_a[i]) rc_a[i] = 3'd0;
    n0 = issue_times.size();
    for (int i = 0; i < 5; i++) send(3'd1, 3'(i), ta);
    wait_issues(n0 + 5, 200);
    if (issue_times.size() >= n0 + 5) begin
      for (int i = 1; i < 5; i++)
        chk("r021_trrd", 32'(issue_times[n0+i] - issue_times[n0+i-1] >= TRRD), 32'd1);
      chk("r021_tfaw", 32'(issue_times[n0+4] - issue_times[n0] >= TFAW), 32'd1);
    end
    run(5);

    // REF waits for bank 6 counter 3 -> 0
    cnt_a[6] = 3;
    n0 = issue_times.size();
    send(3'd5, 3'd6, ta);
    wait_issues(n0 + 1, 30);
    if (issue_times.size() > n0) chk("r022_latency", 32'(issue_times[n0] - ta), 32'd4);
    run(3);

    // Illegal command codes
    base = ill_seen; n0 = issue_times.size();
    send(3'd6, 3'd3, ta); run(2);
    send(3'd0, 3'd1, ta); run(2);
    send(3'd7, 3'd5, ta); run(2);
    chk("r023_ill_count", 32'(ill_seen - base), 32'd3);
    chk("r023_no_issue",  32'(issue_times.size() - n0), 32'd0);

    // Randomized traffic with live-changing bank status
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) cnt_a[$urandom_range(0, NB-1)] = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) rc_a[$urandom_range(0, NB-1)] = rct[$urandom_range(0, 5)];
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_cmd   = 3'($urandom_range(0, 7));
      bus.req_bank  = 3'($urandom_range(0, 7));
      cycle();
    end
    bus.req_valid = 0;
    run(300);
    foreach (rc_a[i]) begin rc_a[i] = 3'd0; cnt_a[i] = 0; end
    run(3);

    // PRE bank 0 blocked by READ_TO_PRECHARGE forever -> timeout
    dec_en = 0; rc_a[0] = 3'd4; cnt_a[0] = 7;
    base = tmo_seen; n0 = issue_times.size();
    send(3'd4, 3'd0, ta);
    run(TMO + 4);
    chk("r024_timeout", 32'(tmo_seen - base), 32'd1);
    chk("r024_no_issue", 32'(issue_times.size() - n0), 32'd0);
    chk("r024_idle", 32'(bus.req_ready), 32'd1);

    // Reset in the middle of WAIT drops the request
    send(3'd4, 3'd0, ta);
    run(5);
    do_reset();
    rc_a[0] = 3'd0; cnt_a[0] = 0;
    t1 = issue_times.size();
    run(10);
    chk("r024_rst_drop", 32'(issue_times.size() - t1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
